// File: rtl/cve2_rvfi_trace_buffer_pkg.sv
// Shared types for the RVFI trace buffer: the packed trace record and FSM state.
package cve2_pkg;

  // One retired instruction. MSB-first field order is part of the readout format.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic        trap;
    logic        intr;
  } trace_rec_t;

  typedef enum logic [1:0] {
    TB_IDLE    = 2'd0,
    TB_CAPTURE = 2'd1,
    TB_FROZEN  = 2'd2
  } trace_state_e;

endpackage

// File: rtl/cve2_rvfi_trace_buffer_if.sv
// RVFI retirement inputs plus the valid/ready record readout, bundled as one port.
interface cve2_rvfi_trace_buffer_if;
  import cve2_pkg::*;

  logic        rvfi_valid_i;
  logic [31:0] rvfi_pc_rdata_i;
  logic [31:0] rvfi_insn_i;
  logic [4:0]  rvfi_rd_addr_i;
  logic [31:0] rvfi_rd_wdata_i;
  logic [31:0] rvfi_mem_addr_i;
  logic [3:0]  rvfi_mem_rmask_i;
  logic [3:0]  rvfi_mem_wmask_i;
  logic        rvfi_trap_i;
  logic        rvfi_intr_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  trace_rec_t  trace_rec_o;

  // Core/debug side: drives retirements and the consumer ready.
  modport master (
    output rvfi_valid_i, rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
           rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i, rvfi_trap_i, rvfi_intr_i,
           trace_ready_i,
    input  trace_valid_o, trace_rec_o
  );

  // Buffer side.
  modport slave (
    input  rvfi_valid_i, rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
           rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i, rvfi_trap_i, rvfi_intr_i,
           trace_ready_i,
    output trace_valid_o, trace_rec_o
  );
endinterface

// File: rtl/cve2_rvfi_trace_buffer_fifo.sv
// Circular FIFO with wrap-bit pointers; storage is reset so the head is never X.
module cve2_trace_fifo #(
  parameter int unsigned Depth = 16,
  parameter type         T     = logic,
  localparam int unsigned PW   = $clog2(Depth) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              data_o,
  output logic [PW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [PW-1:0] wptr_q, rptr_q;
  T              mem_q [Depth];

  assign full_o  = (wptr_q[PW-2:0] == rptr_q[PW-2:0]) && (wptr_q[PW-1] != rptr_q[PW-1]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[PW-2:0]];

  // Pointer update; clear wins over push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PW'(1);
      if (pop_i)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Record storage; only the write slot changes on a push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= T'('0);
    end else if (push_i) begin
      mem_q[wptr_q[PW-2:0]] <= data_i;
    end
  end
endmodule

// File: rtl/cve2_rvfi_trace_buffer.sv
// RVFI trace capture: FSM, push qualification and saturating drop counter around a FIFO.
module cve2_rvfi_trace_buffer
  import cve2_pkg::*;
#(
  parameter int unsigned Depth        = 16,
  parameter int unsigned DropCntWidth = 16,
  parameter bit          FreezeOnTrap = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  cve2_rvfi_trace_buffer_if.slave    bus,
  input  logic                       enable_i,
  input  logic                       clear_i,
  output logic [$clog2(Depth):0]     level_o,
  output logic [DropCntWidth-1:0]    dropped_o,
  output logic                       frozen_o
);
  trace_state_e          state_q, state_d;
  trace_rec_t            rec;
  logic                  push_try, push, drop, pop, full, empty;
  logic [DropCntWidth-1:0] drop_q;

  assign rec = '{pc: bus.rvfi_pc_rdata_i, insn: bus.rvfi_insn_i, rd_addr: bus.rvfi_rd_addr_i,
                 rd_wdata: bus.rvfi_rd_wdata_i, mem_addr: bus.rvfi_mem_addr_i,
                 rmask: bus.rvfi_mem_rmask_i, wmask: bus.rvfi_mem_wmask_i,
                 trap: bus.rvfi_trap_i, intr: bus.rvfi_intr_i};

  // Acceptance looks only at pre-edge fullness, so a same-cycle pop never frees a slot.
  assign push_try = bus.rvfi_valid_i && (state_q == TB_CAPTURE) && !clear_i;
  assign push     = push_try && !full;
  assign drop     = push_try && full;
  assign pop      = !empty && bus.trace_ready_i && !clear_i;

  assign bus.trace_valid_o = !empty;
  assign dropped_o         = drop_q;
  assign frozen_o          = (state_q == TB_FROZEN);

  cve2_trace_fifo #(.Depth(Depth), .T(trace_rec_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clear_i),
    .push_i  (push),
    .data_i  (rec),
    .pop_i   (pop),
    .data_o  (bus.trace_rec_o),
    .level_o (level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // Capture state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= TB_IDLE;
    else         state_q <= state_d;
  end

  // Next state: a stored trap freezes ahead of a same-cycle disable.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TB_IDLE:    if (enable_i) state_d = TB_CAPTURE;
      TB_CAPTURE: begin
        if (push && rec.trap && FreezeOnTrap) state_d = TB_FROZEN;
        else if (!enable_i)                   state_d = TB_IDLE;
      end
      TB_FROZEN:  if (clear_i) state_d = enable_i ? TB_CAPTURE : TB_IDLE;
      default:    state_d = TB_IDLE;
    endcase
  end

  // Dropped-record counter, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                    drop_q <= '0;
    else if (clear_i)               drop_q <= '0;
    else if (drop && (drop_q != '1)) drop_q <= drop_q + DropCntWidth'(1);
  end
endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
// Three buffer configurations driven in lockstep and compared against a queue model.
module tb_cve2_rvfi_trace_buffer;
  import cve2_pkg::*;

  localparam int N = 3;
  // inst0: defaults; inst1: 2-bit drop counter; inst2: freeze on trap.
  localparam int DEPTH [N] = '{16, 16, 16};
  localparam int DCW   [N] = '{16, 2, 16};
  localparam bit FRZ   [N] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, clr = 1'b0, valid = 1'b0, rdy = 1'b0;
  trace_rec_t rec_in = '0;

  logic        o_valid [N];
  trace_rec_t  o_rec   [N];
  logic [4:0]  o_level [N];
  logic [15:0] o_drop  [N];
  logic        o_frz   [N];
  logic [1:0]  drop1;

  int n_asserts = 0, n_fail = 0;

  // Reference model: queue contents, drop count, capture mode (0 idle, 1 capture, 2 frozen).
  trace_rec_t q [N][$];
  int mdrop [N];
  int mmode [N];

  always #5 clk = ~clk;

  cve2_rvfi_trace_buffer_if tif0 ();
  cve2_rvfi_trace_buffer_if tif1 ();
  cve2_rvfi_trace_buffer_if tif2 ();

  assign {tif0.rvfi_pc_rdata_i, tif0.rvfi_insn_i, tif0.rvfi_rd_addr_i, tif0.rvfi_rd_wdata_i,
          tif0.rvfi_mem_addr_i, tif0.rvfi_mem_rmask_i, tif0.rvfi_mem_wmask_i,
          tif0.rvfi_trap_i, tif0.rvfi_intr_i} = rec_in;
  assign {tif1.rvfi_pc_rdata_i, tif1.rvfi_insn_i, tif1.rvfi_rd_addr_i, tif1.rvfi_rd_wdata_i,
          tif1.rvfi_mem_addr_i, tif1.rvfi_mem_rmask_i, tif1.rvfi_mem_wmask_i,
          tif1.rvfi_trap_i, tif1.rvfi_intr_i} = rec_in;
  assign {tif2.rvfi_pc_rdata_i, tif2.rvfi_insn_i, tif2.rvfi_rd_addr_i, tif2.rvfi_rd_wdata_i,
          tif2.rvfi_mem_addr_i, tif2.rvfi_mem_rmask_i, tif2.rvfi_mem_wmask_i,
          tif2.rvfi_trap_i, tif2.rvfi_intr_i} = rec_in;
  assign tif0.rvfi_valid_i = valid;
  assign tif1.rvfi_valid_i = valid;
  assign tif2.rvfi_valid_i = valid;
  assign tif0.trace_ready_i = rdy;
  assign tif1.trace_ready_i = rdy;
  assign tif2.trace_ready_i = rdy;

  assign o_valid[0] = tif0.trace_valid_o;  assign o_rec[0] = tif0.trace_rec_o;
  assign o_valid[1] = tif1.trace_valid_o;  assign o_rec[1] = tif1.trace_rec_o;
  assign o_valid[2] = tif2.trace_valid_o;  assign o_rec[2] = tif2.trace_rec_o;
  assign o_drop[1]  = {14'd0, drop1};

  cve2_rvfi_trace_buffer #(.Depth(16), .DropCntWidth(16), .FreezeOnTrap(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(tif0.slave), .enable_i(en), .clear_i(clr),
    .level_o(o_level[0]), .dropped_o(o_drop[0]), .frozen_o(o_frz[0]));
  cve2_rvfi_trace_buffer #(.Depth(16), .DropCntWidth(2), .FreezeOnTrap(1'b0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(tif1.slave), .enable_i(en), .clear_i(clr),
    .level_o(o_level[1]), .dropped_o(drop1), .frozen_o(o_frz[1]));
  cve2_rvfi_trace_buffer #(.Depth(16), .DropCntWidth(16), .FreezeOnTrap(1'b1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(tif2.slave), .enable_i(en), .clear_i(clr),
    .level_o(o_level[2]), .dropped_o(o_drop[2]), .frozen_o(o_frz[2]));

  task automatic chk(input string tag, input int i, input logic [142:0] obs, input logic [142:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s inst%0d observed=%h expected=%h", tag, i, obs, exp);
    end
  endtask

  function automatic trace_rec_t mk_rec(input logic [31:0] pc, input logic trap);
    trace_rec_t r;
    r.pc = pc;                 r.insn = $urandom;
    r.rd_addr = 5'($urandom);  r.rd_wdata = $urandom;
    r.mem_addr = $urandom;     r.rmask = 4'($urandom);
    r.wmask = 4'($urandom);    r.trap = trap;
    r.intr = 1'($urandom);
    return r;
  endfunction

  // Apply one clock edge's worth of behaviour from the retirement-buffer rules.
  task automatic model_step(input int i);
    bit was_full, do_pop;
    if (!rst_n) begin
      q[i].delete(); mdrop[i] = 0; mmode[i] = 0;
      return;
    end
    if (clr) begin
      q[i].delete(); mdrop[i] = 0; mmode[i] = en ? 1 : 0;
      return;
    end
    do_pop   = (q[i].size() != 0) && rdy;
    was_full = (q[i].size() >= DEPTH[i]);
    if (do_pop) void'(q[i].pop_front());
    if (mmode[i] == 1 && valid) begin
      if (!was_full) q[i].push_back(rec_in);
      else if (mdrop[i] < (1 << DCW[i]) - 1) mdrop[i]++;
      if (!was_full && rec_in.trap && FRZ[i]) mmode[i] = 2;
      else if (!en) mmode[i] = 0;
    end else if (mmode[i] == 0 && en) mmode[i] = 1;
    else if (mmode[i] == 1 && !en) mmode[i] = 0;
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk("valid", i, 143'(o_valid[i]), 143'(q[i].size() != 0));
      chk("level", i, 143'(o_level[i]), 143'(q[i].size()));
      chk("dropped", i, 143'(o_drop[i]), 143'(mdrop[i]));
      chk("frozen", i, 143'(o_frz[i]), 143'(mmode[i] == 2));
      if (q[i].size() != 0) chk("head", i, o_rec[i], q[i][0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) model_step(i);
    #1;
    check_all();
  endtask

  task automatic strobe(input logic [31:0] pc, input logic trap);
    valid = 1'b1; rec_in = mk_rec(pc, trap);
    tick();
    valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin mdrop[i] = 0; mmode[i] = 0; end
    #12;
    check_all();
    for (int i = 0; i < N; i++) chk("rst_level", i, 143'(o_level[i]), 143'(0));
    rst_n = 1'b1;

    // Three records held, then drained in order.
    en = 1'b1; tick();
    strobe(32'h100, 1'b0); strobe(32'h104, 1'b0); strobe(32'h108, 1'b0);
    chk("fill3_level", 0, 143'(o_level[0]), 143'(3));
    chk("fill3_head", 0, 143'(o_rec[0].pc), 143'(32'h100));
    rdy = 1'b1;
    tick(); chk("pop1_pc", 0, 143'(o_rec[0].pc), 143'(32'h104));
    tick(); chk("pop2_pc", 0, 143'(o_rec[0].pc), 143'(32'h108));
    tick(); chk("pop3_valid", 0, 143'(o_valid[0]), 143'(0));
    rdy = 1'b0;

    // Overflow: 20 strobes into 16 entries.
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < 20; k++) strobe(32'h200 + 32'(4 * k), 1'b0);
    chk("ovf_level", 0, 143'(o_level[0]), 143'(16));
    chk("ovf_drop", 0, 143'(o_drop[0]), 143'(4));
    chk("ovf_drop_sat", 1, 143'(o_drop[1]), 143'(3));
    chk("ovf_head", 0, 143'(o_rec[0].pc), 143'(32'h200));

    // Full with simultaneous strobe and pop: push rejected.
    rdy = 1'b1; strobe(32'h300, 1'b0); rdy = 1'b0;
    chk("fullpop_level", 0, 143'(o_level[0]), 143'(15));
    chk("fullpop_drop", 0, 143'(o_drop[0]), 143'(5));
    chk("fullpop_sat", 1, 143'(o_drop[1]), 143'(3));

    // Freeze on the second of four records.
    clr = 1'b1; tick(); clr = 1'b0;
    strobe(32'h400, 1'b0); strobe(32'h404, 1'b1);
    chk("frz_rise", 2, 143'(o_frz[2]), 143'(1));
    strobe(32'h408, 1'b0); strobe(32'h40c, 1'b0);
    chk("frz_level", 2, 143'(o_level[2]), 143'(2));
    chk("frz_drop", 2, 143'(o_drop[2]), 143'(0));
    chk("nofrz_level", 0, 143'(o_level[0]), 143'(4));
    clr = 1'b1; tick(); clr = 1'b0;
    chk("unfrz_level", 2, 143'(o_level[2]), 143'(0));
    chk("unfrz_flag", 2, 143'(o_frz[2]), 143'(0));
    strobe(32'h500, 1'b0);
    chk("unfrz_capture", 2, 143'(o_level[2]), 143'(1));

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      en    = ($urandom_range(0, 15) != 0);
      clr   = ($urandom_range(0, 39) == 0);
      valid = $urandom_range(0, 1);
      rdy   = ($urandom_range(0, 2) == 0);
      rec_in = mk_rec($urandom, $urandom_range(0, 19) == 0);
      tick();
    end

    // Reset mid-stream, then strobes ignored until enable is seen.
    en = 1'b1; clr = 1'b0; rdy = 1'b0;
    for (int k = 0; k < 5; k++) strobe(32'h600 + 32'(4 * k), 1'b0);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) model_step(i);
    check_all();
    for (int i = 0; i < N; i++) chk("midrst_valid", i, 143'(o_valid[i]), 143'(0));
    tick();
    rst_n = 1'b1; en = 1'b0;
    strobe(32'h700, 1'b0); strobe(32'h704, 1'b0);
    chk("idle_ignore", 0, 143'(o_level[0]), 143'(0));
    en = 1'b1;
    strobe(32'h708, 1'b0);
    chk("en_edge_ignore", 0, 143'(o_level[0]), 143'(0));
    strobe(32'h70c, 1'b0);
    chk("capture_again", 0, 143'(o_level[0]), 143'(1));
    chk("capture_pc", 0, 143'(o_rec[0].pc), 143'(32'h70c));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/cve2_rvfi_trace_buffer.md
# cve2_rvfi_trace_buffer

Synthesizable capture buffer for the cve2 RISC-V Formal Interface (RVFI) retirement stream, sitting directly downstream of the core's RVFI outputs in the same position as the simulation tracer. Each retired instruction is packed into one trace record and stored in a circular FIFO. Records are drained over a valid/ready port, so on-chip debug logic can read instruction history on silicon. Overflowing records are dropped and counted, and an optional freeze stops capture at the first trap.

## Interface
- `Depth`, 16: FIFO entries; power of two, ≥ 2.
- `DropCntWidth`, 16: width of the dropped-record counter.
- `FreezeOnTrap`, 1'b0: stop capture after storing the first record with trap = 1.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk_i`  in  1  clock.
  - `rst_ni`  in  1  asynchronous active-low reset.
- RVFI inputs:
  - `rvfi_valid_i`  in  1  retirement strobe.
  - `rvfi_pc_rdata_i`  in  32  PC of the retired instruction.
  - `rvfi_insn_i`  in  32  instruction word.
  - `rvfi_rd_addr_i`  in  5  destination register.
  - `rvfi_rd_wdata_i`  in  32  destination write data.
  - `rvfi_mem_addr_i`  in  32  memory access address.
  - `rvfi_mem_rmask_i`  in  4  memory read byte mask.
  - `rvfi_mem_wmask_i`  in  4  memory write byte mask.
  - `rvfi_trap_i`  in  1  instruction trapped.
  - `rvfi_intr_i`  in  1  first instruction of a trap handler.
- Control:
  - `enable_i`  in  1  capture enable.
  - `clear_i`  in  1  synchronous flush.
- Readout and status:
  - `trace_valid_o`  out  1  a record is available.
  - `trace_ready_i`  in  1  consumer accepts the record.
  - `trace_rec_o`  out  `$bits(trace_rec_t)` (143)  head record.
  - `level_o`  out  `$clog2(Depth)+1`  occupancy.
  - `dropped_o`  out  `DropCntWidth`  saturating count of dropped records.
  - `frozen_o`  out  1  FSM is in FROZEN.

## Operation
- FSM states:
  - IDLE: reset state; no capture.
  - CAPTURE: records are captured.
  - FROZEN: capture has stopped after a trap.
- FSM transitions:
  - IDLE→CAPTURE when `enable_i`=1.
  - CAPTURE→IDLE when `enable_i`=0. Contents are retained.
  - CAPTURE→FROZEN when a record with trap = 1 is pushed and `FreezeOnTrap`=1.
  - FROZEN is left only by `clear_i`. It then goes to CAPTURE if `enable_i`=1, else IDLE.
- Push:
  - A push is attempted when `rvfi_valid_i`=1 and the state is CAPTURE.
  - The push is accepted iff level < Depth, evaluated on pre-edge level and independent of a same-cycle pop.
  - A rejected push increments `dropped_o`, which saturates at all-ones.
  - RVFI strobes in IDLE or FROZEN are ignored and not counted.
- Pop: occurs when `trace_valid_o`=1 and `trace_ready_i`=1. Simultaneous push and pop is legal; level is unchanged.
- Read/write pointers are `$clog2(Depth)+1` bits wide. The MSB is the wrap bit. Full when the indices are equal and the wrap bits differ; empty when the pointers are equal.
- `clear_i` has priority over push and pop in the same cycle. It resets the pointers, `level_o` and `dropped_o` to 0, and releases FROZEN.
- `trace_valid_o` is `level_o` != 0.
- `trace_rec_o` shows the head record combinationally from storage. It is X-free: storage is reset to 0.

## Timing
- Reset value of every output is 0; state is IDLE.
- Push latency: a record accepted at edge N is visible on `trace_valid_o` / `trace_rec_o` after edge N. There is no same-cycle bypass.
- Pop: the head advances at the accepting edge; the next record is valid in the following cycle.
- `trace_rec_o` is stable while `trace_valid_o`=1 and `trace_ready_i`=0.
- `frozen_o` rises in the cycle after the trapping record is pushed.
- When a push and an increment of the full drop counter coincide, `dropped_o` holds its all-ones value.
- Asserting `rst_ni` mid-operation discards all records immediately.

## Structure
- `trace_rec_t` is a packed struct in `cve2_pkg`, fields in MSB→LSB order: pc, insn, rd_addr, rd_wdata, mem_addr, rmask, wmask, trap, intr.
- The FSM state enum also lives in `cve2_pkg`.
- Sub-module `cve2_trace_fifo`, parameterised on Depth and element type, provides storage, pointers and level. The top level holds the FSM, push qualification and the drop counter.

## Test plan
- Enable, then 3 RVFI strobes with pc 0x100/0x104/0x108 while ready=0 → level=3. Then ready=1 → records pop in order, one per cycle, and valid drops after the third.
- Depth=16 and 20 strobes with ready=0 → level=16, `dropped_o`=4, and the head pc equals that of the first strobe.
- FreezeOnTrap=1 and the 2nd of 4 strobes has trap=1 → 2 records stored, `frozen_o`=1, `dropped_o`=0. Then `clear_i` with enable=1 → level=0 and state CAPTURE.
- When full with DropCntWidth=2 and 5 extra strobes → `dropped_o` saturates at 3.
- When full, a simultaneous strobe and pop → push rejected, level=15, `dropped_o` incremented by 1.
- `rst_ni` low mid-stream for one cycle → all outputs 0, and strobes are ignored until `enable_i` is seen in IDLE.
